// File: rtl/traffic_phase_timer.sv
// Per-phase dwell timer feeding the traffic/pedestrian light FSM: loads a dwell per phase,
// counts second ticks, pulses change on expiry. Optional tick pause port under `TIMER_PAUSE_EN.
module traffic_phase_timer #(
  parameter int unsigned T_GREEN   = 20,
  parameter int unsigned T_CLEAR   = 5,
  parameter int unsigned T_YELLOW  = 3,
  parameter int unsigned T_MIN_REM = 8,
  parameter int unsigned CW        = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          tick,
`ifdef TIMER_PAUSE_EN
  input  logic          pause,
`endif
  input  logic [3:0]    state,
  input  logic          ped_req1,
  input  logic          ped_req2,
  output logic          change,
  output logic [CW-1:0] remaining,
  output logic          ped_wait1,
  output logic          ped_wait2,
  output logic          walk_blink
);

  // A zero dwell would never expire, so it is promoted to one tick before truncation.
  localparam logic [CW-1:0] D_GREEN  = CW'((T_GREEN  == 0) ? 32'd1 : T_GREEN);
  localparam logic [CW-1:0] D_CLEAR  = CW'((T_CLEAR  == 0) ? 32'd1 : T_CLEAR);
  localparam logic [CW-1:0] D_YELLOW = CW'((T_YELLOW == 0) ? 32'd1 : T_YELLOW);
  localparam logic [CW-1:0] D_MIN    = CW'(T_MIN_REM);

  typedef enum logic [1:0] {S_LOAD, S_COUNT, S_WAIT_ACK} fsm_t;

  fsm_t          r_fsm;
  fsm_t          w_fsm_nxt;
  logic [3:0]    r_phase;
  logic [3:0]    r_prev_state;
  logic [CW-1:0] w_dwell;
  logic [CW-1:0] w_rem_nxt;
  logic          w_change_nxt;
  logic          w_blink_nxt;
  logic          w_tick;
  logic          w_valid;
  logic          w_jump;
  logic          w_trunc;
  logic          w_blink_phase;
  logic          w_expire;
  logic          w_enter_p0;
  logic          w_enter_p3;

`ifdef TIMER_PAUSE_EN
  assign w_tick = tick & ~pause;
`else
  assign w_tick = tick;
`endif

  always_comb begin
    w_dwell = '0;
    case (state)
      4'd0, 4'd3: w_dwell = D_GREEN;
      4'd1, 4'd4: w_dwell = D_CLEAR;
      4'd2, 4'd5: w_dwell = D_YELLOW;
      default:    w_dwell = '0;
    endcase
  end

  assign w_valid       = (state <= 4'd5);
  assign w_jump        = (state != r_phase);
  assign w_trunc       = (((r_phase == 4'd0) && ped_wait1) || ((r_phase == 4'd3) && ped_wait2))
                         && (remaining > D_MIN);
  assign w_blink_phase = (r_phase == 4'd1) || (r_phase == 4'd4);
  assign w_expire      = w_tick && (remaining == CW'(1));
  assign w_enter_p0    = (state == 4'd0) && (r_prev_state != 4'd0);
  assign w_enter_p3    = (state == 4'd3) && (r_prev_state != 4'd3);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_fsm <= S_LOAD;
    else         r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_LOAD:     w_fsm_nxt = w_valid ? S_COUNT : S_LOAD;
      S_COUNT: begin
        if (w_jump)                   w_fsm_nxt = S_LOAD;
        else if (!w_trunc && w_expire) w_fsm_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: if (w_jump) w_fsm_nxt = S_LOAD;
      default:    w_fsm_nxt = S_LOAD;
    endcase
  end

  // Jump detection outranks truncation, which outranks a coincident tick.
  always_comb begin
    w_rem_nxt    = remaining;
    w_change_nxt = 1'b0;
    w_blink_nxt  = walk_blink;
    case (r_fsm)
      S_LOAD: begin
        w_rem_nxt   = w_dwell;
        w_blink_nxt = 1'b0;
      end
      S_COUNT: begin
        if (w_jump) begin
          w_blink_nxt = 1'b0;
        end else if (w_trunc) begin
          w_rem_nxt = D_MIN;
        end else if (w_tick) begin
          if (w_blink_phase) w_blink_nxt = ~walk_blink;
          if (remaining > CW'(1)) begin
            w_rem_nxt = remaining - CW'(1);
          end else if (remaining == CW'(1)) begin
            w_rem_nxt    = '0;
            w_change_nxt = 1'b1;
          end
        end
      end
      S_WAIT_ACK: if (w_jump) w_blink_nxt = 1'b0;
      default: begin
        w_rem_nxt   = '0;
        w_blink_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      remaining    <= '0;
      change       <= 1'b0;
      walk_blink   <= 1'b0;
      r_phase      <= '0;
      r_prev_state <= '0;
      ped_wait1    <= 1'b0;
      ped_wait2    <= 1'b0;
    end else begin
      remaining    <= w_rem_nxt;
      change       <= w_change_nxt;
      walk_blink   <= w_blink_nxt;
      r_prev_state <= state;
      if (r_fsm == S_LOAD) r_phase <= state;
      ped_wait1    <= ped_req1 | (ped_wait1 & ~w_enter_p3);
      ped_wait2    <= ped_req2 | (ped_wait2 & ~w_enter_p0);
    end
  end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer: directed scenarios plus randomized stimulus against a tick-level reference model.
module tb_traffic_phase_timer;

  localparam int TMIN = 2;

  logic       clock;
  logic       resetn;
  logic       tick;
  logic [3:0] state;
  logic       ped_req1;
  logic       ped_req2;
  logic       pause;
  logic       change;
  logic [7:0] remaining;
  logic       ped_wait1;
  logic       ped_wait2;
  logic       walk_blink;

  traffic_phase_timer #(
    .T_GREEN(6), .T_CLEAR(2), .T_YELLOW(3), .T_MIN_REM(TMIN), .CW(8)
  ) dut (
    .clock(clock), .resetn(resetn), .tick(tick),
`ifdef TIMER_PAUSE_EN
    .pause(pause),
`endif
    .state(state), .ped_req1(ped_req1), .ped_req2(ped_req2),
    .change(change), .remaining(remaining), .ped_wait1(ped_wait1),
    .ped_wait2(ped_wait2), .walk_blink(walk_blink)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int tick_cnt = 0;
  int tick_period = 4;
  bit tick_auto = 1'b1;
  bit adv_pending = 1'b0;

  // Reference model: phase dwell bookkeeping in plain integers.
  int m_rem, m_phase, m_prev;
  bit m_chg, m_w1, m_w2, m_blink, m_loading, m_done;

  function automatic int dwell_of(int p);
    case (p)
      0, 3: return 6;
      1, 4: return 2;
      2, 5: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_rem = 0; m_phase = 0; m_prev = 0;
    m_chg = 0; m_w1 = 0; m_w2 = 0; m_blink = 0; m_loading = 1; m_done = 0;
  endfunction

  function automatic void model_step(int st, bit tk, bit r1, bit r2);
    bit n1, n2;
    n1 = r1 || (m_w1 && !(st == 3 && m_prev != 3));
    n2 = r2 || (m_w2 && !(st == 0 && m_prev != 0));
    m_chg = 0;
    if (m_loading) begin
      m_phase = st;
      m_blink = 0;
      if (st <= 5) begin m_rem = dwell_of(st); m_loading = 0; m_done = 0; end
      else m_rem = 0;
    end else if (st != m_phase) begin
      m_loading = 1;
      m_blink = 0;
    end else if (!m_done) begin
      if (((m_phase == 0 && m_w1) || (m_phase == 3 && m_w2)) && m_rem > TMIN) m_rem = TMIN;
      else if (tk && m_rem > 0) begin
        if (m_phase == 1 || m_phase == 4) m_blink = !m_blink;
        m_rem--;
        if (m_rem == 0) begin m_chg = 1; m_done = 1; end
      end
    end
    m_w1 = n1; m_w2 = n2; m_prev = st;
  endfunction

  function automatic bit m_counting(int st);
    return !m_loading && !m_done && st == m_phase;
  endfunction

  function automatic bit eff_tick();
`ifdef TIMER_PAUSE_EN
    return tick && !pause;
`else
    return tick;
`endif
  endfunction

  // One clock: model sees the same inputs as the DUT; the light FSM advances the cycle after change.
  task automatic step();
    bit tk;
    @(posedge clock);
    tk = eff_tick();
    if (!resetn) model_reset();
    else model_step(int'(state), tk, ped_req1, ped_req2);
    #1;
    if (adv_pending) state = (state >= 4'd5) ? 4'd0 : state + 4'd1;
    adv_pending = m_chg;
    if (tick_auto) begin
      tick_cnt++;
      if (tick_cnt >= tick_period) tick_cnt = 0;
      tick = (tick_cnt == 0);
    end
  endtask

  task automatic wait_for(input int ph, input int rem, output bit ok);
    ok = 0;
    for (int g = 0; g < 1000 && !ok; g++) begin
      step();
      ok = m_counting(int'(state)) && m_phase == ph && m_rem == rem;
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({change, remaining, ped_wait1, ped_wait2, walk_blink} !== 12'h000)
      $display("FAIL reset_outputs got=%h want=000", {change, remaining, ped_wait1, ped_wait2, walk_blink});
    else n_pass++;
    repeat (3) step();
    resetn = 1'b1;
    step();
    n_checks++;
    if (remaining !== 8'd6 || change !== 1'b0)
      $display("FAIL reset_release_load remaining=%0d change=%b want 6/0", remaining, change);
    else n_pass++;
  endtask

  task automatic test_full_cycle();
    int exp_dwell[7] = '{6, 2, 3, 6, 2, 3, 6};
    for (int seg = 0; seg < 7; seg++) begin
      int cnt = 0;
      int g = 0;
      bit cb, tk;
      while (change !== 1'b1 && g < 200) begin
        cb = m_counting(int'(state));
        tk = eff_tick();
        step();
        if (tk && cb) cnt++;
        g++;
        n_checks++;
        if ({change, remaining, ped_wait1, ped_wait2, walk_blink} !== {m_chg, 8'(m_rem), m_w1, m_w2, m_blink})
          $display("FAIL cycle_model seg=%0d got=%h want=%h", seg,
                   {change, remaining, ped_wait1, ped_wait2, walk_blink}, {m_chg, 8'(m_rem), m_w1, m_w2, m_blink});
        else n_pass++;
      end
      n_checks++;
      if (cnt != exp_dwell[seg] || change !== 1'b1)
        $display("FAIL dwell_seg%0d ticks=%0d change=%b want %0d/1", seg, cnt, change, exp_dwell[seg]);
      else n_pass++;
      step();
      n_checks++;
      if (change !== 1'b0) $display("FAIL change_one_cycle seg=%0d got=%b want=0", seg, change);
      else n_pass++;
    end
  endtask

  task automatic count_to_change(input string name, input int want);
    int cnt = 0;
    int g = 0;
    bit tk;
    while (change !== 1'b1 && g < 200) begin
      tk = eff_tick();
      step();
      if (tk) cnt++;
      g++;
    end
    n_checks++;
    if (cnt != want || change !== 1'b1)
      $display("FAIL %s ticks=%0d change=%b want %0d/1", name, cnt, change, want);
    else n_pass++;
  endtask

  task automatic wait_state3_and_check_clear(input string name);
    int g = 0;
    while (state !== 4'd3 && g < 200) begin step(); g++; end
    n_checks++;
    if (ped_wait1 !== 1'b1) $display("FAIL %s_held got=%b want=1", name, ped_wait1);
    else n_pass++;
    step();
    n_checks++;
    if (ped_wait1 !== 1'b0) $display("FAIL %s_clear got=%b want=0", name, ped_wait1);
    else n_pass++;
  endtask

  task automatic test_ped_truncate();
    bit ok;
    wait_for(0, 5, ok);
    n_checks++;
    if (!ok) $display("FAIL trunc_reach got=0 want=1");
    else n_pass++;
    ped_req1 = 1'b1;
    step();
    ped_req1 = 1'b0;
    n_checks++;
    if (ped_wait1 !== 1'b1) $display("FAIL ped1_latch got=%b want=1", ped_wait1);
    else n_pass++;
    step();
    n_checks++;
    if (remaining !== 8'd2) $display("FAIL ped1_truncate remaining=%0d want=2", remaining);
    else n_pass++;
    count_to_change("trunc_expire", 2);
    wait_state3_and_check_clear("trunc_ped1");
  endtask

  task automatic test_ped_late();
    bit ok;
    wait_for(0, 1, ok);
    n_checks++;
    if (!ok) $display("FAIL late_reach got=0 want=1");
    else n_pass++;
    ped_req1 = 1'b1;
    step();
    ped_req1 = 1'b0;
    step();
    n_checks++;
    if (remaining !== 8'd1 || ped_wait1 !== 1'b1)
      $display("FAIL late_no_trunc remaining=%0d wait1=%b want 1/1", remaining, ped_wait1);
    else n_pass++;
    count_to_change("late_expire", 1);
    wait_state3_and_check_clear("late_ped1");
  endtask

  task automatic test_blink();
    bit ok;
    wait_for(1, 2, ok);
    n_checks++;
    if (!ok || walk_blink !== 1'b0) $display("FAIL blink_start got=%b want=0", walk_blink);
    else n_pass++;
    wait_for(1, 1, ok);
    n_checks++;
    if (!ok || walk_blink !== 1'b1) $display("FAIL blink_tick1 got=%b want=1", walk_blink);
    else n_pass++;
    wait_for(2, 3, ok);
    n_checks++;
    if (!ok || walk_blink !== 1'b0) $display("FAIL blink_phase2 got=%b want=0", walk_blink);
    else n_pass++;
  endtask

  task automatic test_reset_midcount();
    bit ok;
    wait_for(0, 4, ok);
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (!ok || {change, remaining, ped_wait1, ped_wait2, walk_blink} !== 12'h000)
      $display("FAIL async_reset got=%h want=000", {change, remaining, ped_wait1, ped_wait2, walk_blink});
    else n_pass++;
    model_reset();
    adv_pending = 1'b0;
    state = 4'd0;
    repeat (2) step();
    resetn = 1'b1;
    step();
    n_checks++;
    if (remaining !== 8'd6) $display("FAIL reset_reload remaining=%0d want=6", remaining);
    else n_pass++;
  endtask

  task automatic test_phase_jump();
    bit ok;
    wait_for(3, 5, ok);
    state = 4'd0;
    step();
    n_checks++;
    if (!ok || change !== 1'b0) $display("FAIL jump_no_pulse change=%b want=0", change);
    else n_pass++;
    step();
    n_checks++;
    if (remaining !== 8'd6 || change !== 1'b0)
      $display("FAIL jump_reload remaining=%0d change=%b want 6/0", remaining, change);
    else n_pass++;
  endtask

`ifdef TIMER_PAUSE_EN
  task automatic test_pause();
    bit ok;
    int cnt = 0;
    int g = 0;
    wait_for(0, 4, ok);
    pause = 1'b1;
    while (cnt < 3 && g < 100) begin
      if (tick) cnt++;
      step();
      g++;
    end
    n_checks++;
    if (!ok || remaining !== 8'd4 || change !== 1'b0)
      $display("FAIL pause_hold remaining=%0d change=%b want 4/0", remaining, change);
    else n_pass++;
    pause = 1'b0;
    count_to_change("pause_resume", 4);
  endtask
`endif

  task automatic test_random();
    tick_auto = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      tick     = ($urandom_range(0, 3) == 0);
      ped_req1 = ($urandom_range(0, 19) == 0);
      ped_req2 = ($urandom_range(0, 19) == 0);
`ifdef TIMER_PAUSE_EN
      pause    = ($urandom_range(0, 7) == 0);
`endif
      if (state > 4'd5) state = 4'd0;
      else if ($urandom_range(0, 299) == 0) state = 4'($urandom_range(0, 5));
      else if ($urandom_range(0, 399) == 0) state = 4'($urandom_range(6, 15));
      step();
      n_checks++;
      if ({change, remaining, ped_wait1, ped_wait2, walk_blink} !== {m_chg, 8'(m_rem), m_w1, m_w2, m_blink})
        $display("FAIL random_model c=%0d got=%h want=%h", c,
                 {change, remaining, ped_wait1, ped_wait2, walk_blink}, {m_chg, 8'(m_rem), m_w1, m_w2, m_blink});
      else n_pass++;
    end
  endtask

  initial begin
    resetn = 1'b0; tick = 1'b0; state = 4'd0;
    ped_req1 = 1'b0; ped_req2 = 1'b0; pause = 1'b0;
    model_reset();
    test_reset();
    test_full_cycle();
    test_ped_truncate();
    test_ped_late();
    test_blink();
    test_reset_midcount();
    test_phase_jump();
`ifdef TIMER_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
